// File: rtl/fizzbuzz_controller.sv
// fizzbuzz_controller
// Run/stop/single-step sequencer for the FizzBuzz counter datapath.
// Each front-panel button passes through a 2-FF synchronizer, a debounce counter
// and a rising-edge detector. The resulting press pulses drive a STOP/RUN/STEP
// FSM. The FSM issues TICK, which advances COUNT and the mod-3/mod-5 residues.
// Optional feature: define FIZZBUZZ_AUTOSTOP_EN to freeze the counter at STOP_AT.

module fizzbuzz_controller #(
   parameter int unsigned DIV_WIDTH      = 21,
   parameter int unsigned DEBOUNCE_WIDTH = 16,
   parameter logic [7:0]  STOP_AT        = 8'd100
) (
   input  logic       CLK20MHz,
   input  logic       RESET_N,
   input  logic       BTN_RUN,
   input  logic       BTN_STEP,
   input  logic       BTN_CLEAR,
   output logic [7:0] COUNT,
   output logic       FIZZ,
   output logic       BUZZ,
   output logic       TICK,
   output logic       RUNNING
);

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   // Bit positions of the three buttons inside the packed button vectors.
   localparam int I_RUN   = 0;
   localparam int I_STEP  = 1;
   localparam int I_CLEAR = 2;

`ifdef FIZZBUZZ_AUTOSTOP_EN
   localparam bit AUTOSTOP = 1'b1;
`else
   localparam bit AUTOSTOP = 1'b0;
`endif

   localparam logic [DEBOUNCE_WIDTH-1:0] DB_MAX  = '1;
   localparam logic [DEBOUNCE_WIDTH-1:0] DB_ONE  = {{(DEBOUNCE_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DIV_WIDTH-1:0]      DIV_MAX = '1;
   localparam logic [DIV_WIDTH-1:0]      DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

   // Button path
   logic [2:0]                btn_raw;
   logic [2:0]                sync1;
   logic [2:0]                sync2;
   logic [2:0]                accepted;
   logic [2:0]                accepted_d;
   logic [2:0]                press;
   logic [DEBOUNCE_WIDTH-1:0] db_cnt [3];

   // FSM and divider
   state_t               state_q;
   state_t               state_n;
   logic [DIV_WIDTH-1:0] div_q;
   logic [DIV_WIDTH-1:0] div_n;
   logic                 tick;

   // Counter datapath
   logic [7:0] count_inc;
   logic [7:0] count_n;
   logic [1:0] fizz_res_q;
   logic [1:0] fizz_res_n;
   logic [2:0] buzz_res_q;
   logic [2:0] buzz_res_n;
   logic       fizz_n;
   logic       buzz_n;
   logic       advance;
   logic       locked;
   logic       hit_stop;
   logic       run_ok;
   logic       step_ok;

   assign btn_raw = {BTN_CLEAR, BTN_STEP, BTN_RUN};

   // Synchronize, debounce and rising-edge detect each button.
   always_ff @(posedge CLK20MHz or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1      <= '0;
         sync2      <= '0;
         accepted   <= '0;
         accepted_d <= '0;
         press      <= '0;
         for (int i = 0; i < 3; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments let sync2 capture the old sync1, which forms a real two-stage synchronizer.
         sync1      <= btn_raw;
         sync2      <= sync1;
         accepted_d <= accepted;
         press      <= accepted & ~accepted_d;
         for (int i = 0; i < 3; i++) begin
            if (sync1[i] != sync2[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] != DB_MAX) begin
               db_cnt[i] <= db_cnt[i] + DB_ONE;
            end
            if (db_cnt[i] == DB_MAX) begin
               accepted[i] <= sync2[i];
            end
         end
      end
   end

   // At the auto-stop value, run and step presses stay locked out until a clear.
   assign locked    = AUTOSTOP && (COUNT == STOP_AT);
   assign run_ok    = press[I_RUN] && !locked;
   assign step_ok   = press[I_STEP] && !locked;
   assign count_inc = COUNT + 8'd1;
   assign advance   = tick && !press[I_CLEAR];
   assign hit_stop  = AUTOSTOP && advance && (count_inc == STOP_AT);

   // Next-state, divider and tick decode.
   always_comb begin
      // NOTE: every output gets a default first, so no path through the case can leave a latch behind.
      state_n = state_q;
      div_n   = div_q;
      tick    = 1'b0;
      unique case (state_q)
         ST_STOP: begin
            if (run_ok) begin
               state_n = ST_RUN;
               div_n   = '0;
            end else if (step_ok) begin
               state_n = ST_STEP;
            end
         end
         ST_RUN: begin
            tick = (div_q == DIV_MAX);
            if (run_ok) begin
               state_n = ST_STOP;
            end else begin
               div_n = div_q + DIV_ONE;
            end
            if (hit_stop) begin
               state_n = ST_STOP;
            end
         end
         ST_STEP: begin
            tick    = 1'b1;
            state_n = ST_STOP;
         end
         default: begin
            state_n = ST_STOP;
         end
      endcase
   end

   // State and divider registers.
   always_ff @(posedge CLK20MHz or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_STOP;
         div_q   <= '0;
      end else begin
         state_q <= state_n;
         div_q   <= div_n;
      end
   end

   // Next count and residues. Clear wins over a tick, and wrap zeroes the residues.
   always_comb begin
      count_n    = COUNT;
      fizz_res_n = fizz_res_q;
      buzz_res_n = buzz_res_q;
      if (press[I_CLEAR]) begin
         count_n    = 8'd0;
         fizz_res_n = 2'd0;
         buzz_res_n = 3'd0;
      end else if (advance) begin
         count_n = count_inc;
         if (COUNT == 8'hFF) begin
            fizz_res_n = 2'd0;
            buzz_res_n = 3'd0;
         end else begin
            fizz_res_n = (fizz_res_q == 2'd2) ? 2'd0 : fizz_res_q + 2'd1;
            buzz_res_n = (buzz_res_q == 3'd4) ? 3'd0 : buzz_res_q + 3'd1;
         end
      end
      fizz_n = (count_n != 8'd0) && (fizz_res_n == 2'd0);
      buzz_n = (count_n != 8'd0) && (buzz_res_n == 3'd0);
   end

   // Count, residue and flag registers all update on the same edge.
   always_ff @(posedge CLK20MHz or negedge RESET_N) begin
      if (!RESET_N) begin
         COUNT      <= 8'd0;
         fizz_res_q <= 2'd0;
         buzz_res_q <= 3'd0;
         FIZZ       <= 1'b0;
         BUZZ       <= 1'b0;
      end else begin
         COUNT      <= count_n;
         fizz_res_q <= fizz_res_n;
         buzz_res_q <= buzz_res_n;
         FIZZ       <= fizz_n;
         BUZZ       <= buzz_n;
      end
   end

   assign TICK    = tick;
   assign RUNNING = (state_q == ST_RUN);

endmodule

// File: tb/tb_fizzbuzz_controller.sv
// tb_fizzbuzz_controller
// Scoreboard bench: tasks push the expected count/flags for each advance they
// provoke, and a negedge monitor pops and compares one entry after every TICK.
// Define FIZZBUZZ_AUTOSTOP_EN to exercise the auto-stop build instead of the wrap.

module tb_fizzbuzz_controller;

   localparam int DIV_W       = 4;
   localparam int DEB_W       = 3;
   localparam int TICK_PERIOD = 2 ** DIV_W;
   localparam int PRESS_LAT   = 2 + 2 ** DEB_W + 1;
   localparam int B_RUN       = 0;
   localparam int B_STEP      = 1;
   localparam int B_CLEAR     = 2;

   typedef struct packed {
      logic [7:0] c;
      logic       f;
      logic       b;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_run;
   logic       btn_step;
   logic       btn_clear;
   logic [7:0] count;
   logic       fizz;
   logic       buzz;
   logic       tick;
   logic       running;

   int   checks = 0;
   int   failures = 0;
   exp_t sb_q[$];
   exp_t sb_e;
   bit   sb_armed = 1'b0;
   bit   tick_prev = 1'b0;
   int   tick_seen = 0;
   int   cyc = 0;

   always #5 clk = ~clk;

   fizzbuzz_controller #(
      .DIV_WIDTH      (DIV_W),
      .DEBOUNCE_WIDTH (DEB_W),
      .STOP_AT        (8'd100)
   ) dut (
      .CLK20MHz  (clk),
      .RESET_N   (rst_n),
      .BTN_RUN   (btn_run),
      .BTN_STEP  (btn_step),
      .BTN_CLEAR (btn_clear),
      .COUNT     (count),
      .FIZZ      (fizz),
      .BUZZ      (buzz),
      .TICK      (tick),
      .RUNNING   (running)
   );

   // Reference FizzBuzz for the n-th advance from zero, with 8-bit wrap.
   function automatic exp_t model(input int n);
      exp_t e;
      int   c;
      c   = n % 256;
      e.c = 8'(c);
      e.f = (c != 0) && (c % 3 == 0);
      e.b = (c != 0) && (c % 5 == 0);
      return e;
   endfunction

   // The cycle after each TICK, the new count and flags must match the scoreboard head.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (sb_armed && tick_prev) begin
         checks = checks + 1;
         if (sb_q.size() == 0) begin
            failures = failures + 1;
            $display("FAIL unexpected_tick: count=%0d but no advance was expected", count);
         end else begin
            sb_e = sb_q.pop_front();
            if ({count, fizz, buzz} !== sb_e) begin
               failures = failures + 1;
               $display("FAIL sb_advance: got count=%0d fizz=%0b buzz=%0b, expected count=%0d fizz=%0b buzz=%0b",
                        count, fizz, buzz, sb_e.c, sb_e.f, sb_e.b);
            end
         end
      end
      tick_prev = tick;
      if (tick) tick_seen = tick_seen + 1;
   end

   task automatic wait_ticks(input int target, input int budget);
      int n = 0;
      while (tick_seen < target && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (tick_seen < target) begin
         checks   = checks + 1;
         failures = failures + 1;
         $display("FAIL tick_timeout: saw %0d ticks, expected %0d", tick_seen, target);
      end
   endtask

   task automatic press_btn(input int which, input int hold);
      case (which)
         B_RUN:   btn_run   = 1'b1;
         B_STEP:  btn_step  = 1'b1;
         default: btn_clear = 1'b1;
      endcase
      repeat (hold) @(negedge clk);
      btn_run   = 1'b0;
      btn_step  = 1'b0;
      btn_clear = 1'b0;
      repeat (2 ** DEB_W + 6) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      btn_run   = 1'b0;
      btn_step  = 1'b0;
      btn_clear = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks = checks + 1;
      if ({count, fizz, buzz, tick, running} !== 12'd0) begin
         failures = failures + 1;
         $display("FAIL reset_outputs: got count=%0d fizz=%0b buzz=%0b tick=%0b running=%0b, expected all 0",
                  count, fizz, buzz, tick, running);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      checks = checks + 1;
      if ({count, tick, running} !== 10'd0) begin
         failures = failures + 1;
         $display("FAIL reset_idle: got count=%0d tick=%0b running=%0b, expected 0 0 0", count, tick, running);
      end
      sb_armed = 1'b1;
   endtask

   task automatic test_step;
      int base = tick_seen;
      sb_q.push_back(model(1));
      press_btn(B_STEP, 20);
      #1;
      checks = checks + 1;
      if (tick_seen - base !== 1) begin
         failures = failures + 1;
         $display("FAIL step_tick_count: got %0d ticks, expected 1", tick_seen - base);
      end
      checks = checks + 1;
      if ({count, fizz, buzz, running} !== {8'd1, 1'b0, 1'b0, 1'b0}) begin
         failures = failures + 1;
         $display("FAIL step_result: got count=%0d fizz=%0b buzz=%0b running=%0b, expected 1 0 0 0",
                  count, fizz, buzz, running);
      end
   endtask

   task automatic test_clear_idle;
      press_btn(B_CLEAR, 14);
      #1;
      checks = checks + 1;
      if ({count, fizz, buzz, running} !== 11'd0) begin
         failures = failures + 1;
         $display("FAIL clear_idle: got count=%0d fizz=%0b buzz=%0b running=%0b, expected 0 0 0 0",
                  count, fizz, buzz, running);
      end
   endtask

   task automatic stop_run;
      press_btn(B_RUN, 14);
      #1;
      checks = checks + 1;
      if (running !== 1'b0) begin
         failures = failures + 1;
         $display("FAIL stop_run: got running=%0b, expected 0", running);
      end
   endtask

   task automatic test_run;
      int base = tick_seen;
      int last = 0;
      for (int i = 1; i <= 15; i++) sb_q.push_back(model(i));
      @(negedge clk);
      btn_run = 1'b1;
      repeat (PRESS_LAT) @(negedge clk);
      #1;
      checks = checks + 1;
      if (running !== 1'b0) begin
         failures = failures + 1;
         $display("FAIL run_latency_early: got running=%0b, expected 0", running);
      end
      @(negedge clk);
      #1;
      checks = checks + 1;
      if (running !== 1'b1) begin
         failures = failures + 1;
         $display("FAIL run_latency: got running=%0b, expected 1", running);
      end
      repeat (3) @(negedge clk);
      btn_run = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         wait_ticks(base + i, TICK_PERIOD * 2 + 20);
         if (i > 1) begin
            checks = checks + 1;
            if (cyc - last !== TICK_PERIOD) begin
               failures = failures + 1;
               $display("FAIL run_tick_spacing: got %0d cycles, expected %0d", cyc - last, TICK_PERIOD);
            end
         end
         last = cyc;
      end
      @(negedge clk);
      #1;
      checks = checks + 1;
      if ({count, fizz, buzz, running} !== {8'd15, 1'b1, 1'b1, 1'b1}) begin
         failures = failures + 1;
         $display("FAIL run_count15: got count=%0d fizz=%0b buzz=%0b running=%0b, expected 15 1 1 1",
                  count, fizz, buzz, running);
      end
      stop_run();
   endtask

   task automatic test_glitch;
      int base = tick_seen;
      for (int i = 0; i < 15; i++) begin
         btn_run = ~btn_run;
         repeat (2) @(negedge clk);
      end
      btn_run = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      checks = checks + 1;
      if ({running, count} !== {1'b0, 8'd15} || tick_seen != base) begin
         failures = failures + 1;
         $display("FAIL glitch_filter: got running=%0b count=%0d ticks=%0d, expected 0 15 0",
                  running, count, tick_seen - base);
      end
   endtask

   task automatic test_clear_on_tick;
      int base;
      test_clear_idle();
      base = tick_seen;
      for (int i = 1; i <= 9; i++) sb_q.push_back(model(i));
      press_btn(B_RUN, 14);
      wait_ticks(base + 9, TICK_PERIOD * 12);
      sb_q.push_back(model(0));
      sb_q.push_back(model(1));
      // Land the clear pulse exactly on the tenth tick.
      repeat (TICK_PERIOD - PRESS_LAT) @(negedge clk);
      btn_clear = 1'b1;
      wait_ticks(base + 10, TICK_PERIOD * 2);
      @(negedge clk);
      #1;
      btn_clear = 1'b0;
      checks = checks + 1;
      if ({count, fizz, buzz} !== 10'd0) begin
         failures = failures + 1;
         $display("FAIL clear_on_tick: got count=%0d fizz=%0b buzz=%0b, expected 0 0 0", count, fizz, buzz);
      end
      wait_ticks(base + 11, TICK_PERIOD * 2);
      @(negedge clk);
      #1;
      checks = checks + 1;
      if (count !== 8'd1) begin
         failures = failures + 1;
         $display("FAIL clear_next_tick: got count=%0d, expected 1", count);
      end
      stop_run();
   endtask

`ifndef FIZZBUZZ_AUTOSTOP_EN
   task automatic test_wrap;
      int base;
      test_clear_idle();
      base = tick_seen;
      for (int i = 1; i <= 261; i++) sb_q.push_back(model(i));
      press_btn(B_RUN, 14);
      wait_ticks(base + 261, TICK_PERIOD * 270);
      @(negedge clk);
      #1;
      checks = checks + 1;
      if ({count, fizz, buzz} !== {8'd5, 1'b0, 1'b1} || sb_q.size() != 0) begin
         failures = failures + 1;
         $display("FAIL wrap_end: got count=%0d fizz=%0b buzz=%0b pending=%0d, expected 5 0 1 0",
                  count, fizz, buzz, sb_q.size());
      end
      stop_run();
   endtask
`else
   task automatic test_autostop;
      int base;
      test_clear_idle();
      base = tick_seen;
      for (int i = 1; i <= 100; i++) sb_q.push_back(model(i));
      press_btn(B_RUN, 14);
      wait_ticks(base + 100, TICK_PERIOD * 110);
      @(negedge clk);
      #1;
      checks = checks + 1;
      if ({count, buzz, running} !== {8'd100, 1'b1, 1'b0}) begin
         failures = failures + 1;
         $display("FAIL autostop_hit: got count=%0d buzz=%0b running=%0b, expected 100 1 0", count, buzz, running);
      end
      press_btn(B_STEP, 14);
      press_btn(B_RUN, 14);
      repeat (TICK_PERIOD * 2) @(negedge clk);
      #1;
      checks = checks + 1;
      if ({count, running} !== {8'd100, 1'b0} || tick_seen != base + 100) begin
         failures = failures + 1;
         $display("FAIL autostop_locked: got count=%0d running=%0b extra_ticks=%0d, expected 100 0 0",
                  count, running, tick_seen - base - 100);
      end
      test_clear_idle();
      sb_q.push_back(model(1));
      press_btn(B_STEP, 14);
      #1;
      checks = checks + 1;
      if (count !== 8'd1) begin
         failures = failures + 1;
         $display("FAIL autostop_reenable: got count=%0d, expected 1", count);
      end
   endtask
`endif

   task automatic test_reset_midrun;
      sb_armed = 1'b0;
      press_btn(B_RUN, 14);
      repeat (TICK_PERIOD * 2) @(negedge clk);
      #1;
      checks = checks + 1;
      if (running !== 1'b1 || count == 8'd0) begin
         failures = failures + 1;
         $display("FAIL midrun_pre: got running=%0b count=%0d, expected running 1 and nonzero count", running, count);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks = checks + 1;
      if ({count, fizz, buzz, tick, running} !== 12'd0) begin
         failures = failures + 1;
         $display("FAIL midrun_async_reset: got count=%0d fizz=%0b buzz=%0b tick=%0b running=%0b, expected all 0",
                  count, fizz, buzz, tick, running);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sb_q.delete();
      repeat (TICK_PERIOD * 2) @(negedge clk);
      #1;
      checks = checks + 1;
      if ({count, running} !== 9'd0) begin
         failures = failures + 1;
         $display("FAIL midrun_after: got count=%0d running=%0b, expected 0 0", count, running);
      end
   endtask

   initial begin
      test_reset();
      test_step();
      test_clear_idle();
      test_run();
      test_glitch();
      test_clear_on_tick();
`ifndef FIZZBUZZ_AUTOSTOP_EN
      test_wrap();
`else
      test_autostop();
`endif
      test_reset_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
